// File: rtl/rv_vp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_vp_pkg
//  Description : Shared widths and writeback result-source encoding for the
//                scalar/vector RV32I-based core pipeline registers.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_vp_pkg;

    localparam int unsigned INSTR_W = 32;   // instruction and PC width
    localparam int unsigned DATA_W  = 128;  // 4 x 32-bit lanes
    localparam int unsigned RD_W    = 6;    // MSB selects scalar vs vector file
    localparam int unsigned RES_W   = 2;    // result_source select width

    // Writeback mux select. 2'b11 is reserved and is passed through untouched.
    typedef enum logic [RES_W-1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_source_e;

endpackage : rv_vp_pkg
`default_nettype wire

// File: rtl/pipe_writeback_vp_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg
//  Description : Parameterized pipeline register with stage enable and
//                asynchronous active-low clear.
//  Ports       : clock       - rising-edge clock
//                async_reset - asynchronous active-low clear
//                i_enable    - 1 captures i_d, 0 holds
//                i_d / o_q   - WIDTH-bit data in / registered data out
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             async_reset,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            r_q <= '0;
        end else if (i_enable) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : pipe_reg
`default_nettype wire

// File: rtl/pipe_writeback_vp.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_writeback_vp
//  Description : Memory-to-writeback pipeline register. Pure storage: every
//                _M field is captured into its _W copy on an enabled rising
//                edge and cleared asynchronously while async_reset is low.
//  Ports       : clock, async_reset (active-low, async), enabler (1 = capture)
//                instruction, write_scalar_reg, result_source,
//                write_vector_reg, rd, ALU_result_bus, read_data_bus,
//                PC_plus_4 - _M inputs and registered _W outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_writeback_vp #(
    parameter int unsigned INSTR_W = rv_vp_pkg::INSTR_W,
    parameter int unsigned DATA_W  = rv_vp_pkg::DATA_W,
    parameter int unsigned RD_W    = rv_vp_pkg::RD_W
) (
    input  logic                          clock,
    input  logic                          async_reset,
    input  logic                          enabler,

    input  logic [INSTR_W-1:0]            instruction_M,
    input  logic                          write_scalar_reg_M,
    input  logic [rv_vp_pkg::RES_W-1:0]   result_source_M,
    input  logic                          write_vector_reg_M,
    input  logic [RD_W-1:0]               rd_M,
    input  logic [DATA_W-1:0]             ALU_result_bus_M,
    input  logic [DATA_W-1:0]             read_data_bus_M,
    input  logic [INSTR_W-1:0]            PC_plus_4_M,

    output logic [INSTR_W-1:0]            instruction_W,
    output logic                          write_scalar_reg_W,
    output logic [rv_vp_pkg::RES_W-1:0]   result_source_W,
    output logic                          write_vector_reg_W,
    output logic [RD_W-1:0]               rd_W,
    output logic [DATA_W-1:0]             ALU_result_bus_W,
    output logic [DATA_W-1:0]             read_data_bus_W,
    output logic [INSTR_W-1:0]            PC_plus_4_W
);

    import rv_vp_pkg::*;

    // All fields travel as one bundle through a single register so that a
    // shared enable can never leave the stage partially updated.
    localparam int unsigned c_BUNDLE_W = INSTR_W + 1 + RES_W + 1 + RD_W
                                       + DATA_W + DATA_W + INSTR_W;

    logic [c_BUNDLE_W-1:0] w_bundle_m;
    logic [c_BUNDLE_W-1:0] w_bundle_w;

    assign w_bundle_m = {instruction_M, write_scalar_reg_M, result_source_M,
                         write_vector_reg_M, rd_M, ALU_result_bus_M,
                         read_data_bus_M, PC_plus_4_M};

    pipe_reg #(
        .WIDTH (c_BUNDLE_W)
    ) u_mw_reg (
        .clock       (clock),
        .async_reset (async_reset),
        .i_enable    (enabler),
        .i_d         (w_bundle_m),
        .o_q         (w_bundle_w)
    );

    assign {instruction_W, write_scalar_reg_W, result_source_W,
            write_vector_reg_W, rd_W, ALU_result_bus_W,
            read_data_bus_W, PC_plus_4_W} = w_bundle_w;

endmodule : pipe_writeback_vp
`default_nettype wire

// File: tb/tb_pipe_writeback_vp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_writeback_vp
//  Description : Scoreboard bench for the M->W pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_writeback_vp;

    typedef struct packed {
        logic [31:0]  instr;
        logic         ws;
        logic [1:0]   rs;
        logic         wv;
        logic [5:0]   rd;
        logic [127:0] alu;
        logic [127:0] rdata;
        logic [31:0]  pc4;
    } wb_t;

    logic         clock;
    logic         async_reset;
    logic         enabler;
    logic [31:0]  instruction_M, instruction_W;
    logic         write_scalar_reg_M, write_scalar_reg_W;
    logic [1:0]   result_source_M, result_source_W;
    logic         write_vector_reg_M, write_vector_reg_W;
    logic [5:0]   rd_M, rd_W;
    logic [127:0] ALU_result_bus_M, ALU_result_bus_W;
    logic [127:0] read_data_bus_M, read_data_bus_W;
    logic [31:0]  PC_plus_4_M, PC_plus_4_W;

    pipe_writeback_vp dut (
        .clock              (clock),
        .async_reset        (async_reset),
        .enabler            (enabler),
        .instruction_M      (instruction_M),
        .write_scalar_reg_M (write_scalar_reg_M),
        .result_source_M    (result_source_M),
        .write_vector_reg_M (write_vector_reg_M),
        .rd_M               (rd_M),
        .ALU_result_bus_M   (ALU_result_bus_M),
        .read_data_bus_M    (read_data_bus_M),
        .PC_plus_4_M        (PC_plus_4_M),
        .instruction_W      (instruction_W),
        .write_scalar_reg_W (write_scalar_reg_W),
        .result_source_W    (result_source_W),
        .write_vector_reg_W (write_vector_reg_W),
        .rd_W               (rd_W),
        .ALU_result_bus_W   (ALU_result_bus_W),
        .read_data_bus_W    (read_data_bus_W),
        .PC_plus_4_W        (PC_plus_4_W)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int  checks = 0;
    int  errors = 0;
    wb_t sb[$];       // expected outputs, one entry per upcoming falling edge
    wb_t model;       // what the writeback stage should currently hold
    bit  rst_low;     // bench-side view of the reset pin
    wb_t act;

    assign act = {instruction_W, write_scalar_reg_W, result_source_W,
                  write_vector_reg_W, rd_W, ALU_result_bus_W,
                  read_data_bus_W, PC_plus_4_W};

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input wb_t e);
        check({tag, ".instr"}, 128'(act.instr), 128'(e.instr));
        check({tag, ".ws"},    128'(act.ws),    128'(e.ws));
        check({tag, ".rs"},    128'(act.rs),    128'(e.rs));
        check({tag, ".wv"},    128'(act.wv),    128'(e.wv));
        check({tag, ".rd"},    128'(act.rd),    128'(e.rd));
        check({tag, ".alu"},   act.alu,         e.alu);
        check({tag, ".rdata"}, act.rdata,       e.rdata);
        check({tag, ".pc4"},   128'(act.pc4),   128'(e.pc4));
    endtask

    // Monitor: compares away from the active edge.
    always @(negedge clock) begin
        if (sb.size() > 0) check_all("sb", sb.pop_front());
    end

    function automatic wb_t rand_wb();
        wb_t r;
        r.instr = $urandom;
        r.ws    = 1'($urandom);
        r.rs    = 2'($urandom);
        r.wv    = 1'($urandom);
        r.rd    = 6'($urandom);
        r.alu   = {$urandom, $urandom, $urandom, $urandom};
        r.rdata = {$urandom, $urandom, $urandom, $urandom};
        r.pc4   = $urandom;
        return r;
    endfunction

    task automatic drive(input wb_t f, input bit en);
        instruction_M      = f.instr;
        write_scalar_reg_M = f.ws;
        result_source_M    = f.rs;
        write_vector_reg_M = f.wv;
        rd_M               = f.rd;
        ALU_result_bus_M   = f.alu;
        read_data_bus_M    = f.rdata;
        PC_plus_4_M        = f.pc4;
        enabler            = en;
    endtask

    // Drives inputs now, then 1 ns after the edge records what the stage
    // should show and idles until edge+2, so the next call's input change
    // lands 2 ns after the edge and must not reach the outputs before the
    // next edge.
    task automatic cycle(input wb_t f, input bit en);
        drive(f, en);
        @(posedge clock);
        #1;
        if (rst_low)  model = '0;
        else if (en)  model = f;
        sb.push_back(model);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        wb_t cap, hold, w;

        // Reset held low for 13 ns, clock running, inputs busy.
        async_reset = 1'b0;
        rst_low     = 1'b1;
        model       = '0;
        drive(rand_wb(), 1'b1);
        @(posedge clock);
        #1;
        sb.push_back('0);
        #7;                         // t = 13 ns
        async_reset = 1'b1;
        rst_low     = 1'b0;

        // Directed capture.
        cap.instr = 32'hABCD_EF01;
        cap.ws    = 1'b1;
        cap.rs    = 2'b10;
        cap.wv    = 1'b1;
        cap.rd    = 6'b011010;
        cap.alu   = 128'h0123456789ABCDEF0123456789ABCDEF;
        cap.rdata = 128'hFEDCBA9876543210FEDCBA9876543210;
        cap.pc4   = 32'h8000_0004;
        cycle(cap, 1'b1);

        // Hold with all inputs changed, then re-enable.
        hold       = '0;
        hold.instr = 32'h0000_0013;
        hold.rs    = 2'b01;
        hold.alu   = 128'h5;
        hold.pc4   = 32'h0000_1000;
        repeat (3) cycle(hold, 1'b0);
        cycle(hold, 1'b1);
        cycle(cap, 1'b1);

        // Async clear mid-cycle, after the falling-edge check.
        @(negedge clock);
        #1;
        async_reset = 1'b0;
        rst_low     = 1'b1;
        model       = '0;
        #1;
        check_all("async_clear", '0);
        repeat (2) cycle(rand_wb(), 1'b1);
        async_reset = 1'b1;          // released between edges
        rst_low     = 1'b0;
        cycle(rand_wb(), 1'b0);      // disabled edge after release: still 0
        cycle(rand_wb(), 1'b1);

        // Walking one per field, everything else zero.
        for (int b = 0; b < 128; b++) begin
            w = '0; w.alu = 128'(1) << b; cycle(w, 1'b1);
        end
        for (int b = 0; b < 128; b++) begin
            w = '0; w.rdata = 128'(1) << b; cycle(w, 1'b1);
        end
        for (int b = 0; b < 6; b++) begin
            w = '0; w.rd = 6'(1) << b; cycle(w, 1'b1);
        end
        for (int b = 0; b < 32; b++) begin
            w = '0; w.instr = 32'(1) << b; w.pc4 = 32'(1) << (31 - b); cycle(w, 1'b1);
        end
        w = '0; w.ws = 1'b1; cycle(w, 1'b1);
        w = '0; w.wv = 1'b1; cycle(w, 1'b1);
        w = '0; w.rs = 2'b11; cycle(w, 1'b1);

        // Randomized enable and data.
        for (int i = 0; i < 300; i++) begin
            cycle(rand_wb(), ($urandom_range(0, 9) < 7));
        end

        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_writeback_vp
`default_nettype wire
